// File: rtl/spl_host_mem_responder_if.sv
// SPL request/response bundle between the AFU core (master) and the host-side responder (slave).
interface spl_host_mem_responder_if;
  logic [57:0]  base_addr;
  logic         cor_tx_rd_valid;
  logic [57:0]  cor_tx_rd_addr;
  logic         cor_tx_wr_valid;
  logic         cor_tx_fence_valid;
  logic [57:0]  cor_tx_wr_addr;
  logic [511:0] cor_tx_data;
  logic         rsp_stall;
  logic         wr_stall;
  logic         spl_tx_rd_almostfull;
  logic         spl_tx_wr_almostfull;
  logic         io_rx_rd_valid;
  logic [511:0] io_rx_data;
  logic         rd_overflow;
  logic         oow_err;
  logic [15:0]  fence_cnt;

  modport master (
    output base_addr, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_wr_valid,
           cor_tx_fence_valid, cor_tx_wr_addr, cor_tx_data, rsp_stall, wr_stall,
    input  spl_tx_rd_almostfull, spl_tx_wr_almostfull, io_rx_rd_valid, io_rx_data,
           rd_overflow, oow_err, fence_cnt
  );

  modport slave (
    input  base_addr, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_wr_valid,
           cor_tx_fence_valid, cor_tx_wr_addr, cor_tx_data, rsp_stall, wr_stall,
    output spl_tx_rd_almostfull, spl_tx_wr_almostfull, io_rx_rd_valid, io_rx_data,
           rd_overflow, oow_err, fence_cnt
  );
endinterface

// File: rtl/spl_host_mem_responder.sv
// Host memory model answering SPL reads in order from a local line memory.
// Path: request FIFO -> registered memory read at pop -> delay pipe -> io_rx.
module spl_host_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int FIFO_AW  = 4,
  parameter int AFULL_TH = 12,
  parameter int LATENCY  = 8
) (
  input logic                    CLK_400M,
  input logic                    reset_n,
  spl_host_mem_responder_if.slave bus
);
  // pop edge is stage 0; response appears LATENCY-2 stages later
  localparam int STAGES = LATENCY - 2;
  localparam int DEPTH  = 1 << FIFO_AW;

  typedef struct packed {
    logic              inwin;
    logic [ADDR_W-1:0] idx;
  } rd_req_t;

  logic [511:0] mem [2**ADDR_W];
  rd_req_t      fifo_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][511:0]     dat_pipe;
  logic         afull_q, wr_af_q, ovf_q, oow_q;
  logic [15:0]  fence_q;

  logic [57:0]  rd_off, wr_off;
  logic         rd_inwin, wr_inwin, full, empty, push, pop, drop, wr_mem, fence;
  rd_req_t      head;
  logic [511:0] rd_data;

  // window offsets wrap modulo 2**58
  assign rd_off   = bus.cor_tx_rd_addr - bus.base_addr;
  assign wr_off   = bus.cor_tx_wr_addr - bus.base_addr;
  assign rd_inwin = (rd_off[57:ADDR_W] == '0);
  assign wr_inwin = (wr_off[57:ADDR_W] == '0);

  assign full   = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign pop    = !empty && !bus.rsp_stall;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign push   = bus.cor_tx_rd_valid && (!full || pop);
  assign drop   = bus.cor_tx_rd_valid && full && !pop;
  assign cnt_d  = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  assign fence  = bus.cor_tx_wr_valid && bus.cor_tx_fence_valid;
  assign wr_mem = bus.cor_tx_wr_valid && !bus.cor_tx_fence_valid && wr_inwin;

  // write-first bypass when a write hits the line being popped
  assign head    = fifo_q[rptr_q];
  assign rd_data = !head.inwin ? '0 :
                   (wr_mem && wr_off[ADDR_W-1:0] == head.idx) ? bus.cor_tx_data : mem[head.idx];

  // line memory: contents survive reset
  always_ff @(posedge CLK_400M)
    if (wr_mem) mem[wr_off[ADDR_W-1:0]] <= bus.cor_tx_data;

  // request FIFO storage
  always_ff @(posedge CLK_400M)
    if (push) fifo_q[wptr_q] <= '{inwin: rd_inwin, idx: rd_off[ADDR_W-1:0]};

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      afull_q <= 1'b0;
      wr_af_q <= 1'b0;
      ovf_q   <= 1'b0;
      oow_q   <= 1'b0;
      fence_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      afull_q <= (cnt_d >= (FIFO_AW+1)'(AFULL_TH));
      wr_af_q <= bus.wr_stall;
      ovf_q   <= ovf_q | drop;
      oow_q   <= oow_q | (bus.cor_tx_rd_valid && !rd_inwin)
                       | (bus.cor_tx_wr_valid && !bus.cor_tx_fence_valid && !wr_inwin);
      if (fence) fence_q <= fence_q + 16'd1;
    end
  end

  // response valid shift register; reset discards everything in flight
  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1:0], pop};
  end

  // response data shift register, qualified by vld_pipe at the output
  always_ff @(posedge CLK_400M)
    dat_pipe <= {dat_pipe[STAGES-1:0], rd_data};

  assign bus.io_rx_rd_valid       = vld_pipe[STAGES];
  assign bus.io_rx_data           = vld_pipe[STAGES] ? dat_pipe[STAGES] : '0;
  assign bus.spl_tx_rd_almostfull = afull_q;
  assign bus.spl_tx_wr_almostfull = wr_af_q;
  assign bus.rd_overflow          = ovf_q;
  assign bus.oow_err              = oow_q;
  assign bus.fence_cnt            = fence_q;
endmodule

// File: tb/tb_spl_host_mem_responder.sv
// Directed bench for spl_host_mem_responder: latency, ordering, back-pressure, window, fence, reset.
module tb_spl_host_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spl_host_mem_responder_if bus();
  spl_host_mem_responder dut (.CLK_400M(clk), .reset_n(rst_n), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [511:0] rq_d[$];
  int           rq_c[$];
  localparam logic [57:0]  BASE = 58'h100;
  localparam logic [511:0] A5   = {64{8'hA5}};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // capture every response with its cycle; data must be zero when idle
  always @(negedge clk) begin
    if (bus.io_rx_rd_valid) begin
      rq_d.push_back(bus.io_rx_data);
      rq_c.push_back(cyc);
    end else if (rst_n) begin
      chk("idle_data_zero", bus.io_rx_data, '0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_line(input logic [57:0] a, input logic [511:0] d);
    bus.cor_tx_wr_valid = 1'b1; bus.cor_tx_wr_addr = a; bus.cor_tx_data = d;
    step();
    bus.cor_tx_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [57:0] a);
    bus.cor_tx_rd_valid = 1'b1; bus.cor_tx_rd_addr = a;
    step();
    bus.cor_tx_rd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int k = 0;
    while (rq_d.size() < n && k < budget) begin step(); k++; end
    chk(tag, 512'(rq_d.size() >= n), 512'd1);
  endtask

  task automatic clr();
    rq_d.delete(); rq_c.delete();
  endtask

  initial begin
    int c;
    bus.base_addr = BASE; bus.cor_tx_rd_valid = 0; bus.cor_tx_rd_addr = '0;
    bus.cor_tx_wr_valid = 0; bus.cor_tx_fence_valid = 0; bus.cor_tx_wr_addr = '0;
    bus.cor_tx_data = '0; bus.rsp_stall = 0; bus.wr_stall = 0;
    repeat (3) step();
    chk("rst_valid", 512'(bus.io_rx_rd_valid), 0);
    chk("rst_data", bus.io_rx_data, 0);
    chk("rst_rd_af", 512'(bus.spl_tx_rd_almostfull), 0);
    chk("rst_wr_af", 512'(bus.spl_tx_wr_almostfull), 0);
    chk("rst_ovf", 512'(bus.rd_overflow), 0);
    chk("rst_oow", 512'(bus.oow_err), 0);
    chk("rst_fence", 512'(bus.fence_cnt), 0);
    rst_n = 1'b1;
    step();

    // 1: write then uncontended read, latency 8
    wr_line(BASE + 3, A5);
    step();
    c = cyc;
    rd(BASE + 3);
    wait_rsp("t1_wait", 1, 30);
    chk("t1_data", rq_d[0], A5);
    chk("t1_latency", 512'(rq_c[0] - c), 512'd8);
    clr();

    // 2: 8 back-to-back reads
    for (int i = 0; i < 8; i++) wr_line(BASE + 58'(i), 512'(i));
    c = cyc;
    for (int i = 0; i < 8; i++) rd(BASE + 58'(i));
    wait_rsp("t2_wait", 8, 40);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_data%0d", i), rq_d[i], 512'(i));
      chk($sformatf("t2_cyc%0d", i), 512'(rq_c[i] - c), 512'(8 + i));
    end
    clr();

    // write-first: write to the same line at the pop edge
    c = cyc;
    bus.cor_tx_rd_valid = 1'b1; bus.cor_tx_rd_addr = BASE + 5;
    step();
    bus.cor_tx_rd_valid = 1'b0;
    wr_line(BASE + 5, 512'hBEEF);
    wait_rsp("wf_wait", 1, 30);
    chk("wf_data", rq_d[0], 512'hBEEF);
    chk("wf_latency", 512'(rq_c[0] - c), 512'd8);
    clr();

    // 3: stalled FIFO fills, almostfull at 12, 17th dropped
    for (int i = 0; i < 16; i++) wr_line(BASE + 58'(32 + i), 512'(100 + i));
    bus.rsp_stall = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      rd(BASE + 58'(32 + k - 1));
      if (k == 11) chk("t3_af_11", 512'(bus.spl_tx_rd_almostfull), 0);
      if (k == 12) chk("t3_af_12", 512'(bus.spl_tx_rd_almostfull), 1);
      if (k == 16) chk("t3_ovf_16", 512'(bus.rd_overflow), 0);
    end
    chk("t3_ovf_17", 512'(bus.rd_overflow), 1);
    repeat (10) step();
    chk("t3_stalled_none", 512'(rq_d.size()), 0);
    bus.rsp_stall = 1'b0;
    wait_rsp("t3_wait", 16, 60);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_data%0d", i), rq_d[i], 512'(100 + i));
      chk($sformatf("t3_b2b%0d", i), 512'(rq_c[i] - rq_c[0]), 512'(i));
    end
    repeat (10) step();
    chk("t3_count", 512'(rq_d.size()), 16);
    chk("t3_af_clear", 512'(bus.spl_tx_rd_almostfull), 0);
    chk("t3_ovf_sticky", 512'(bus.rd_overflow), 1);
    clr();

    // 4: fence does not touch memory
    wr_line(BASE + 3, A5);
    bus.cor_tx_fence_valid = 1'b1;
    wr_line(BASE + 3, 512'h0);
    bus.cor_tx_fence_valid = 1'b0;
    chk("t4_fence_cnt", 512'(bus.fence_cnt), 1);
    rd(BASE + 3);
    wait_rsp("t4_wait", 1, 30);
    chk("t4_data", rq_d[0], A5);
    clr();

    // write almostfull follows wr_stall by one cycle
    chk("wraf_0", 512'(bus.spl_tx_wr_almostfull), 0);
    bus.wr_stall = 1'b1;
    step();
    chk("wraf_1", 512'(bus.spl_tx_wr_almostfull), 1);
    bus.wr_stall = 1'b0;
    step();
    chk("wraf_off", 512'(bus.spl_tx_wr_almostfull), 0);

    // 5: out-of-window reads return 0 in order
    wr_line(BASE + 0, 512'hDEAD);
    chk("t5_oow_pre", 512'(bus.oow_err), 0);
    rd(BASE + 1024);
    rd(BASE - 1);
    rd(BASE + 0);
    wait_rsp("t5_wait", 3, 30);
    chk("t5_hi", rq_d[0], 0);
    chk("t5_lo", rq_d[1], 0);
    chk("t5_inwin", rq_d[2], 512'hDEAD);
    chk("t5_oow", 512'(bus.oow_err), 1);
    clr();

    // 6: reset in the middle of a 10-read burst
    for (int i = 0; i < 9; i++) rd(BASE + 58'(i));
    chk("t6_valid_pre", 512'(bus.io_rx_rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 512'(bus.io_rx_rd_valid), 0);
    chk("t6_data", bus.io_rx_data, 0);
    chk("t6_ovf", 512'(bus.rd_overflow), 0);
    chk("t6_oow", 512'(bus.oow_err), 0);
    chk("t6_fence", 512'(bus.fence_cnt), 0);
    rd(BASE + 9);
    step();
    clr();
    rst_n = 1'b1;
    repeat (20) step();
    chk("t6_no_rsp", 512'(rq_d.size()), 0);
    rd(BASE + 3);
    wait_rsp("t6_wait", 1, 30);
    chk("t6_new", rq_d[0], A5);
    clr();

    // out-of-window write is ignored and flags the error
    wr_line(BASE + 1024, 512'h1234);
    chk("oow_wr_flag", 512'(bus.oow_err), 1);
    rd(BASE + 0);
    wait_rsp("oow_wr_wait", 1, 30);
    chk("oow_wr_ignored", rq_d[0], 512'hDEAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
